reg_serial_reader: RTL and testbench

Read-side companion to the 8-bit load register. The block captures the register's parallel output on request and streams it out one bit per accepted transfer over a valid/ready serial interface. It sits between a datapath register's `q` bus and a narrow debug or output port. It signals completion with a one-cycle `done` pulse and is locked against re-trigger until the current word has fully drained.

---
 rtl/reg_serial_reader.sv | 69 ++++++
 tb/tb_reg_serial_reader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reg_serial_reader.sv
// Captures a parallel word on start and streams it out one bit per accepted
// valid/ready transfer, pulsing done once the whole word has drained.
module reg_serial_reader #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] d,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [CW-1:0]    r_cnt;
   logic             w_xfer;
   logic             w_head_bit;
   logic [WIDTH-1:0] w_shreg_next;

   // Outputs decode from registered state only, so ser_valid never sees ser_ready.
   assign ser_valid = (r_state == S_SHIFT);
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);

   assign w_head_bit   = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
   assign ser_out      = ser_valid & w_head_bit;
   assign w_xfer       = ser_valid & ser_ready;
   assign w_shreg_next = LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_shreg <= d;
                  r_cnt   <= '0;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (w_xfer) begin
                  r_shreg <= w_shreg_next;
                  r_cnt   <= r_cnt + 1'b1;
                  if (r_cnt == LAST_CNT) r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_serial_reader.sv
// Directed bench: three instances (8-bit LSB-first, 8-bit MSB-first, 4-bit LSB-first)
// sharing clock and reset, with hand-computed bit sequences.
module tb_reg_serial_reader;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic       l_start = 0, l_ready = 0;
   logic [7:0] l_d = '0;
   logic       l_out, l_valid, l_busy, l_done;

   logic       m_start = 0, m_ready = 0;
   logic [7:0] m_d = '0;
   logic       m_out, m_valid, m_busy, m_done;

   logic       s_start = 0, s_ready = 0;
   logic [3:0] s_d = '0;
   logic       s_out, s_valid, s_busy, s_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_serial_reader #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .start(l_start), .d(l_d), .ser_out(l_out),
      .ser_valid(l_valid), .ser_ready(l_ready), .busy(l_busy), .done(l_done));

   reg_serial_reader #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .start(m_start), .d(m_d), .ser_out(m_out),
      .ser_valid(m_valid), .ser_ready(m_ready), .busy(m_busy), .done(m_done));

   reg_serial_reader #(.WIDTH(4), .LSB_FIRST(1'b1)) u_w4 (
      .clk(clk), .rst(rst), .start(s_start), .d(s_d), .ser_out(s_out),
      .ser_valid(s_valid), .ser_ready(s_ready), .busy(s_busy), .done(s_done));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   logic [7:0] exp8;
   logic [3:0] exp4;
   logic [3:0] rdy_pat;
   int         bitidx, cycles, stalls, k, done_seen;

   initial begin
      // Asynchronous reset before any clock edge: outputs must go low at once.
      #2 rst = 1'b1;
      #1;
      chk("rst_valid", {31'd0, l_valid}, 32'd0);
      chk("rst_busy",  {31'd0, l_busy},  32'd0);
      chk("rst_done",  {31'd0, l_done},  32'd0);
      chk("rst_out",   {31'd0, l_out},   32'd0);
      chk("rst_busy_m", {31'd0, m_busy}, 32'd0);
      chk("rst_busy_s", {31'd0, s_busy}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("post_rst_busy", {31'd0, l_busy}, 32'd0);
      chk("post_rst_valid", {31'd0, l_valid}, 32'd0);

      // Back-to-back stream, 0xA5 LSB first.
      exp8 = 8'hA5;
      l_d = 8'hA5; l_ready = 1'b1; l_start = 1'b1;
      @(negedge clk);
      l_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("a5_valid", {31'd0, l_valid}, 32'd1);
         chk($sformatf("a5_bit%0d", i), {31'd0, l_out}, {31'd0, exp8[i]});
         chk("a5_nodone", {31'd0, l_done}, 32'd0);
         @(negedge clk);
      end
      chk("a5_done", {31'd0, l_done}, 32'd1);
      chk("a5_done_valid", {31'd0, l_valid}, 32'd0);
      chk("a5_done_busy", {31'd0, l_busy}, 32'd1);
      @(negedge clk);
      chk("a5_idle_busy", {31'd0, l_busy}, 32'd0);
      chk("a5_idle_done", {31'd0, l_done}, 32'd0);

      // MSB first with backpressure 1,0,0,1 repeating: 0x3C -> 0,0,1,1,1,1,0,0.
      exp8 = 8'h3C; rdy_pat = 4'b1001;
      m_d = 8'h3C; m_start = 1'b1;
      @(negedge clk);
      m_start = 1'b0;
      bitidx = 0; cycles = 0; stalls = 0; k = 0;
      while (!m_done && cycles < 40) begin
         chk("3c_valid", {31'd0, m_valid}, 32'd1);
         if (bitidx < 8)
            chk($sformatf("3c_bit%0d", bitidx), {31'd0, m_out}, {31'd0, exp8[7-bitidx]});
         m_ready = rdy_pat[k % 4];
         if (m_ready) bitidx++; else stalls++;
         k++; cycles++;
         @(negedge clk);
      end
      m_ready = 1'b0;
      chk("3c_done_seen", {31'd0, m_done}, 32'd1);
      chk("3c_bits_at_done", bitidx, 32'd8);
      chk("3c_length", cycles, 32'd16);
      chk("3c_stalls", stalls, 32'd8);
      chk("3c_done_valid", {31'd0, m_valid}, 32'd0);
      @(negedge clk);
      chk("3c_idle_busy", {31'd0, m_busy}, 32'd0);

      // Input isolation and re-trigger lockout: 0x96 -> 0,1,1,0,1,0,0,1.
      exp8 = 8'h96; done_seen = 0;
      l_d = 8'h96; l_ready = 1'b1; l_start = 1'b1;
      @(negedge clk);
      l_start = 1'b0; l_d = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("iso_bit%0d", i), {31'd0, l_out}, {31'd0, exp8[i]});
         chk("iso_valid", {31'd0, l_valid}, 32'd1);
         if (l_done) done_seen++;
         l_start = (i == 3);
         @(negedge clk);
      end
      chk("iso_done", {31'd0, l_done}, 32'd1);
      if (l_done) done_seen++;
      l_start = 1'b1;
      @(negedge clk);
      l_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("iso_no_retrigger", {31'd0, l_valid}, 32'd0);
         chk("iso_idle_busy", {31'd0, l_busy}, 32'd0);
         if (l_done) done_seen++;
         @(negedge clk);
      end
      chk("iso_done_count", done_seen, 32'd1);

      // Reset mid-word after 3 transfers.
      l_d = 8'hA5; l_ready = 1'b1; l_start = 1'b1;
      @(negedge clk);
      l_start = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("mid_pre_valid", {31'd0, l_valid}, 32'd1);
      chk("mid_pre_bit3", {31'd0, l_out}, 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, l_valid}, 32'd0);
      chk("mid_rst_busy", {31'd0, l_busy}, 32'd0);
      chk("mid_rst_done", {31'd0, l_done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 3; i++) begin
         if (l_done) done_seen++;
         chk("mid_after_valid", {31'd0, l_valid}, 32'd0);
         @(negedge clk);
      end
      chk("mid_no_done", done_seen, 32'd0);
      exp8 = 8'h01;
      l_d = 8'h01; l_start = 1'b1;
      @(negedge clk);
      l_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("r01_bit%0d", i), {31'd0, l_out}, {31'd0, exp8[i]});
         chk("r01_valid", {31'd0, l_valid}, 32'd1);
         @(negedge clk);
      end
      chk("r01_done", {31'd0, l_done}, 32'd1);
      @(negedge clk);

      // WIDTH=4, 4'b1001 LSB first -> 1,0,0,1.
      exp4 = 4'b1001;
      s_d = 4'b1001; s_ready = 1'b1; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("w4_bit%0d", i), {31'd0, s_out}, {31'd0, exp4[i]});
         chk("w4_valid", {31'd0, s_valid}, 32'd1);
         @(negedge clk);
      end
      chk("w4_done", {31'd0, s_done}, 32'd1);
      chk("w4_done_valid", {31'd0, s_valid}, 32'd0);
      @(negedge clk);
      chk("w4_idle_busy", {31'd0, s_busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
